// File: rtl/sram_client_arbiter.sv
// Two-client round-robin arbiter in front of a single-port SRAM macro.
// One transaction in flight: accept, issue, wait read latency, respond.
module sram_client_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic grant;
  logic acc0;
  logic acc1;
  logic rsp_hs;

  // Ready is combinational but masked while reset holds the outputs low.
  always_comb begin
    grant  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    acc0   = (state_q == IDLE) && !ASYNCRESET && req0_valid && !grant;
    acc1   = (state_q == IDLE) && !ASYNCRESET && req1_valid && grant;
    rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc0 || acc1) begin
          owner_d = acc1;
          wr_d    = acc1 ? req1_write : req0_write;
          addr_d  = acc1 ? req1_addr  : req0_addr;
          wdata_d = acc1 ? req1_wdata : req0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d   = CW'(READ_LATENCY);
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    req0_ready = acc0;
    req1_ready = acc1;
    mem_cen    = (state_q == ISSUE);
    mem_wen    = (state_q == ISSUE) && wr_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) && owner_q;
    rsp0_rdata = rsp0_valid ? rdata_q : '0;
    rsp1_rdata = rsp1_valid ? rdata_q : '0;
    owner      = owner_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: doc/sram_client_arbiter.md
Name: sram_client_arbiter

Overview:
- Shares one single-port SRAM macro between two independent clients. Each client has its own request and response channel.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences each access: accept, issue, wait for read latency, respond.
- Sits between client-side protocol state machines and the SRAM macro in the onyx SRAM subsystem.

Parameters:
DATA_WIDTH, 16, width of write data, read data and SRAM word
ADDR_WIDTH, 9, SRAM word address width
READ_LATENCY, 1, cycles from the read-issue cycle to valid mem_rdata; must be at least 1

Ports:
CLK  in  1  clock; all state updates on rising edge
ASYNCRESET  in  1  asynchronous, active-high reset
req0_valid  in  1  client 0 request valid
req0_ready  out  1  client 0 request accepted this cycle
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_WIDTH  client 0 address
req0_wdata  in  DATA_WIDTH  client 0 write data
rsp0_valid  out  1  client 0 response valid
rsp0_ready  in  1  client 0 takes the response
rsp0_rdata  out  DATA_WIDTH  read data; 0 for write acknowledges
req1_*/rsp1_*  same set as client 0, for client 1
mem_cen  out  1  SRAM chip enable, asserted for one cycle per access
mem_wen  out  1  SRAM write enable; valid only when mem_cen=1
mem_addr  out  ADDR_WIDTH  SRAM address
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM read data
owner  out  1  client owning the current transaction
busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, CLK. ASYNCRESET is asynchronous and active-high.
- While ASYNCRESET is high:
  - state=IDLE, priority pointer=0, owner=0.
  - All captured registers are 0.
  - All outputs are 0.
- Reset asserted mid-transaction aborts it:
  - no response is produced;
  - mem_cen drops immediately;
  - clients must reissue.
- States: IDLE, ISSUE, RWAIT, RESP.
- IDLE, grant selection:
  - Only one reqN_valid high: grant that client.
  - Both high: grant the client named by the priority pointer.
  - reqN_ready is combinational and equals (state==IDLE & grant==N). At most one ready per cycle.
  - On the accepting edge: capture write/addr/wdata, set owner=N, go to ISSUE.
- ISSUE, exactly one cycle:
  - mem_cen=1, mem_wen=captured write, mem_addr and mem_wdata from the captured registers.
  - Write: next state RESP with rdata register=0.
  - Read: next state RWAIT with the latency counter loaded to READ_LATENCY.
- RWAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter equals 1: capture mem_rdata and go to RESP.
  - READ_LATENCY=1 therefore spends exactly one RWAIT cycle.
- RESP:
  - rsp<owner>_valid=1 and rsp<owner>_rdata=captured data, held stable until rsp<owner>_ready=1.
  - The other client's rsp_valid=0.
  - On handshake: priority pointer becomes ~owner, next state IDLE.
- Outside ISSUE: mem_cen=0 and mem_wen=0. mem_addr and mem_wdata hold the captured values.
- Outside RESP: rspN_valid=0 and rspN_rdata=0.
- busy=1 in every state except IDLE.
- Latency from request acceptance edge to rsp_valid:
  - write: 2 cycles;
  - read: 2+READ_LATENCY cycles.
  - The new request is accepted at the earliest in the cycle after the response handshake, because IDLE lasts at least one cycle.
- Fairness: a client holding reqN_valid waits behind at most one transaction of the other client.
- Clients must hold valid and payload stable until ready. If a valid drops before grant, the arbiter simply does not accept it; there is no internal state to corrupt.
- Requests arriving outside IDLE see ready=0 and are not lost, provided the client holds them.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Reset → all outputs 0 and busy=0. Assert ASYNCRESET during RWAIT → mem_cen=0, no rsp, state IDLE.
- Client 0 writes addr 0x005 / data 0xBEEF:
  - cycle 0: req0_ready=1;
  - cycle 1: mem_cen=1, mem_wen=1, mem_addr=0x005, mem_wdata=0xBEEF;
  - cycle 2: rsp0_valid=1, rsp0_rdata=0.
- Client 1 reads 0x005, READ_LATENCY=1, memory model returns 0xBEEF:
  - mem_cen=1, mem_wen=0 one cycle after accept;
  - rsp1_valid=1 with rsp1_rdata=0xBEEF three cycles after accept.
- Both clients hold valid continuously after reset:
  - grant order is 0,1,0,1;
  - owner alternates;
  - no two readies in the same cycle.
- Hold rsp0_ready=0 for 5 cycles during RESP:
  - rsp0_valid and rsp0_rdata stay stable;
  - req1_ready stays 0;
  - client 1 is granted the cycle after rsp0_ready=1 handshake plus IDLE.
- READ_LATENCY=3: the read response appears exactly 5 cycles after acceptance, with data sampled 3 cycles after the ISSUE cycle.
